// File: rtl/sram_controller.sv
// External-SRAM controller for the MEM stage: splits one DATA_W access into
// DATA_W/SRAM_DW narrow beats, each held WAIT_CYCLES clocks; ready low = freeze.
module sram_controller #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DW     = 16,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic                op_wr;
  logic [DATA_W-1:0]   wdata_sh;
  logic [BW-1:0]       beat_cnt;
  logic [WW-1:0]       wait_cnt;
  logic                req;
  logic                wait_last;
  logic                beat_last;
  logic [SRAM_AW-1:0]  beat0_addr;

  assign req       = read_en | write_en;
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign beat_last = (beat_cnt == BEAT_LAST);

  // Word index scaled to beats; truncation gives the silent modulo-2^SRAM_AW wrap.
  assign beat0_addr = SRAM_AW'(((address - BASE_ADDR) >> BYTE_SH) * 32'(BEATS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        sram_dq_oe = op_wr;
        sram_we_n  = ~op_wr;
        if (wait_last && beat_last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write data is kept as a shift register so the next beat slice is always at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr       <= 1'b0;
      wdata_sh    <= '0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr       <= write_en;
            wdata_sh    <= write_data >> SRAM_DW;
            sram_dq_out <= write_data[SRAM_DW-1:0];
            sram_addr   <= beat0_addr;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
          end
        end
        ACCESS: begin
          if (!op_wr && wait_last) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_cnt == BW'(b)) read_data[b*SRAM_DW +: SRAM_DW] <= sram_dq_in;
            end
          end
          if (wait_last) begin
            wait_cnt <= '0;
            if (!beat_last) begin
              beat_cnt    <= beat_cnt + 1'b1;
              sram_addr   <= sram_addr + 1'b1;
              sram_dq_out <= wdata_sh[SRAM_DW-1:0];
              wdata_sh    <= wdata_sh >> SRAM_DW;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Parametrised external-SRAM controller for the MEM stage of the ARM pipeline. It replaces the single-cycle data memory.
- It accepts one DATA_W-bit read or write per request and splits it into BEATS = DATA_W/SRAM_DW narrow SRAM beats, each held for WAIT_CYCLES clocks.
- It drives ready low while busy. The pipeline uses ~ready as its global freeze, which is the source of the top-level freeze net.

Parameters:
DATA_W, 32, request data width; must be an integer multiple of SRAM_DW.
SRAM_DW, 16, SRAM data-bus width.
SRAM_AW, 18, SRAM address-bus width (beat-granular address).
WAIT_CYCLES, 2, clocks each beat is held; minimum 1.
BASE_ADDR, 1024, CPU byte address that maps to SRAM beat 0.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
read_en  input  1  MEM-stage load request.
write_en  input  1  MEM-stage store request.
address  input  32  CPU byte address (ALU result).
write_data  input  DATA_W  store data (val_Rm).
read_data  output  DATA_W  load data; registered, holds last completed read.
ready  output  1  transaction complete / no request pending; pipeline freeze = ~ready.
sram_addr  output  SRAM_AW  SRAM beat address.
sram_dq_out  output  SRAM_DW  SRAM write data.
sram_dq_in  input  SRAM_DW  SRAM read data.
sram_dq_oe  output  1  high = controller drives the data bus.
sram_we_n  output  1  active-low SRAM write strobe.

Behaviour:
- Reset (async, any state) sets every output as follows:
  - state=IDLE
  - read_data=0, sram_addr=0, sram_dq_out=0
  - sram_dq_oe=0, sram_we_n=1
  - beat and wait counters=0
  - An in-flight write is abandoned; no further beats are issued.
- States and transitions:
  - IDLE: if read_en|write_en, latch the op, write_data and the computed word index, clear the counters, and go to ACCESS. If both enables are high, the op is a write.
  - ACCESS: beat b is held for WAIT_CYCLES clocks.
    - On the last wait cycle of beat b, a read samples sram_dq_in into read_data[b*SRAM_DW +: SRAM_DW].
    - After beat BEATS-1 completes, go to DONE; otherwise b increments.
  - DONE: one cycle, then IDLE.
- Address mapping (all arithmetic modulo 2^SRAM_AW):
  - word index = (address - BASE_ADDR) >> log2(DATA_W/8); the low byte-offset bits are ignored.
  - sram_addr = word_index*BEATS + b.
  - Out-of-range addresses wrap silently.
- Beat order is little-endian: beat 0 carries bits [SRAM_DW-1:0].
- Write strobe and data bus:
  - Writes: in ACCESS, sram_dq_oe=1, sram_we_n=0, sram_dq_out = the beat slice.
  - Reads: sram_we_n=1, sram_dq_oe=0.
- ready (combinational) = (state==DONE) | (state==IDLE & ~read_en & ~write_en).
  - ready=0 throughout ACCESS and in the IDLE cycle that accepts a request.
- Latency: with the request in IDLE at cycle 0, ready=0 for cycles 0..BEATS*WAIT_CYCLES. ready=1 in cycle BEATS*WAIT_CYCLES+1 (DONE), with read_data valid in that cycle.
- Back-to-back requests: the pipeline advances at DONE. The next request is seen in the following IDLE cycle, giving exactly one IDLE cycle between transactions.
- Request deassertion mid-transaction is ignored; the latched transaction completes.
- read_data changes only during read beats; writes leave it untouched.

Test Plan:
- Idle after reset, enables low -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write address=1028, data=0xDEADBEEF (defaults) ->
  - sram_addr=2 with dq_out=0xBEEF and we_n=0 for cycles 1-2, then sram_addr=3 with dq_out=0xDEAD for cycles 3-4.
  - ready low in cycles 0-4, high in cycle 5.
- Read address=1028 against an SRAM model holding that data -> read_data=0xDEADBEEF and ready=1 in cycle 5; sram_we_n stays 1.
- Write 1024 then read 1024 with enables held back-to-back -> two 6-cycle transactions separated by one IDLE cycle, and the read returns the written word.
- Assert rst in cycle 2 of a write -> all outputs immediately at reset values; the beat-1 address is never driven. After release, a read of the same address returns the old upper half.
- Parameter sweep DATA_W=64, SRAM_DW=16, WAIT_CYCLES=1, write address=BASE_ADDR+8 -> four beats at sram_addr 4..7, ready high in cycle 5.
